seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for the clock's 7-segment display bank.

---
 rtl/seg_scan_ctrl_pkg.sv | 13 +
 rtl/seg_scan_ctrl_if.sv | 27 ++
 rtl/seg_scan_ctrl_timer.sv | 49 ++++
 rtl/seg_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_ctrl_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t CODE_BLANK = 4'hF;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bus between timekeeping logic, the scan controller and the display pins.
interface seg_scan_if #(
  parameter int unsigned N_DIGITS = 4
);
  import seg_scan_ctrl_pkg::*;

  logic                    scan_en;
  logic [4*N_DIGITS-1:0]   digits;
  logic [N_DIGITS-1:0]     dp_mask;
  logic [N_DIGITS-1:0]     blink_mask;
  logic                    blink_en;
  digit_t                  code;
  logic [N_DIGITS-1:0]     an_n;
  logic                    dp_n;
  logic                    frame_done;

  modport master (
    output scan_en, digits, dp_mask, blink_mask, blink_en,
    input  code, an_n, dp_n, frame_done
  );

  modport slave (
    input  scan_en, digits, dp_mask, blink_mask, blink_en,
    output code, an_n, dp_n, frame_done
  );

endinterface

// File: rtl/seg_scan_ctrl_timer.sv
// Slot timer: cycle-in-slot counter, slot index and end-of-frame pulse.
// Next-count values are exported so the controller can register outputs aligned to them.
module scan_slot_timer #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         scan_en,
  output logic [$clog2(SCAN_DIV)-1:0]  cnt,
  output logic [$clog2(N_DIGITS)-1:0]  idx,
  output logic [$clog2(SCAN_DIV)-1:0]  cnt_nxt_c,
  output logic [$clog2(N_DIGITS)-1:0]  idx_nxt_c,
  output logic                         frame_done
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Disabled scanning parks the timer at the start of slot 0.
  always_comb begin
    cnt_nxt_c = cnt;
    idx_nxt_c = idx;
    if (!scan_en) begin
      cnt_nxt_c = '0;
      idx_nxt_c = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt_c = '0;
      idx_nxt_c = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt_nxt_c = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt_c;
      idx        <= idx_nxt_c;
      frame_done <= scan_en && (idx_nxt_c == IDX_LAST) && (cnt_nxt_c == CNT_LAST);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with anti-ghost blanking,
// frame-coherent digit capture, per-digit blink and decimal points.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 128
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned FC_W  = $clog2(BLINK_FRAMES) + 1;

  localparam logic [0:0] S_BLANK = ST_BLANK;
  localparam logic [0:0] S_DRIVE = ST_DRIVE;

  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_nxt;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          idx_nxt;
  logic                      frame_done;

  logic [0:0]                state;
  logic [0:0]                state_nxt;
  logic [4*N_DIGITS-1:0]     shadow;
  logic [4*N_DIGITS-1:0]     shadow_nxt;
  logic [N_DIGITS-1:0]       shadow_dp;
  logic [N_DIGITS-1:0]       shadow_dp_nxt;
  logic [FC_W-1:0]           frame_cnt;
  logic [FC_W-1:0]           frame_cnt_nxt;
  logic                      blink_phase;
  logic                      blink_phase_nxt;

  digit_t                    code_q;
  digit_t                    code_nxt;
  logic [N_DIGITS-1:0]       an_n_q;
  logic [N_DIGITS-1:0]       an_n_nxt;
  logic                      dp_n_q;
  logic                      dp_n_nxt;

  scan_slot_timer #(
    .N_DIGITS (N_DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (bus.scan_en),
    .cnt        (cnt),
    .idx        (idx),
    .cnt_nxt_c  (cnt_nxt),
    .idx_nxt_c  (idx_nxt),
    .frame_done (frame_done)
  );

  // Shadow capture at frame start; blink phase advances once per BLINK_FRAMES frames.
  always_comb begin
    shadow_nxt      = shadow;
    shadow_dp_nxt   = shadow_dp;
    frame_cnt_nxt   = frame_cnt;
    blink_phase_nxt = blink_phase;
    if (bus.scan_en && (cnt == '0) && (idx == '0)) begin
      shadow_nxt    = bus.digits;
      shadow_dp_nxt = bus.dp_mask;
    end
    if (bus.scan_en && frame_done) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_nxt   = '0;
        blink_phase_nxt = ~blink_phase;
      end else begin
        frame_cnt_nxt = frame_cnt + FC_W'(1);
      end
    end
  end

  // Next-state and next-output logic, evaluated against the upcoming cnt/idx.
  always_comb begin
    state_nxt = state;
    code_nxt  = CODE_BLANK;
    an_n_nxt  = '1;
    dp_n_nxt  = 1'b1;
    case (state)
      S_BLANK: if (bus.scan_en && (cnt_nxt >= CNT_W'(BLANK_CYC))) state_nxt = S_DRIVE;
      S_DRIVE: if (!bus.scan_en || (cnt_nxt == '0))                state_nxt = S_BLANK;
      default: state_nxt = S_BLANK;
    endcase
    if (state_nxt == S_DRIVE) begin
      an_n_nxt = ~(N_DIGITS'(1) << idx_nxt);
      if (!(bus.blink_en && bus.blink_mask[idx_nxt] && !blink_phase_nxt)) begin
        code_nxt = shadow_nxt[{idx_nxt, 2'b00} +: 4];
        dp_n_nxt = ~shadow_dp_nxt[idx_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BLANK;
      shadow      <= '1;
      shadow_dp   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
      code_q      <= CODE_BLANK;
      an_n_q      <= '1;
      dp_n_q      <= 1'b1;
    end else begin
      state       <= state_nxt;
      shadow      <= shadow_nxt;
      shadow_dp   <= shadow_dp_nxt;
      frame_cnt   <= frame_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      code_q      <= code_nxt;
      an_n_q      <= an_n_nxt;
      dp_n_q      <= dp_n_nxt;
    end
  end

  assign bus.code       = code_q;
  assign bus.an_n       = an_n_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a frame-level reference model.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FR = ND * SD;

  logic clk;
  logic rst_n;

  seg_scan_if #(.N_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .N_DIGITS     (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYC    (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position within the frame, completed frames, captured digits.
  int          t;
  int          frames;
  logic [3:0]  sh    [ND];
  logic        sh_dp [ND];
  logic [3:0]  e_code;
  logic [ND-1:0] e_an;
  logic        e_dp;
  logic        e_fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t (frame pos %0d)", tag, got, exp, $time, t % FR);
    end
  endtask

  task automatic model_blank();
    e_code = 4'hF;
    e_an   = '1;
    e_dp   = 1'b1;
    e_fd   = 1'b0;
  endtask

  task automatic model_reset();
    t      = 0;
    frames = 0;
    for (int i = 0; i < ND; i++) begin
      sh[i]    = 4'hF;
      sh_dp[i] = 1'b0;
    end
    model_blank();
  endtask

  task automatic model_edge();
    int q;
    int slot;
    int c;
    if (!bus.scan_en) begin
      t = 0;
      model_blank();
    end else begin
      if (t % FR == 0) begin
        for (int i = 0; i < ND; i++) begin
          sh[i]    = bus.digits[4*i +: 4];
          sh_dp[i] = bus.dp_mask[i];
        end
      end
      if (t % FR == FR - 1) frames++;
      t++;
      q    = t % FR;
      slot = q / SD;
      c    = q % SD;
      model_blank();
      e_fd = (q == FR - 1);
      if (c >= BC) begin
        e_an[slot] = 1'b0;
        if (!(bus.blink_en && bus.blink_mask[slot] && ((frames / BF) % 2 == 1))) begin
          e_code = sh[slot];
          e_dp   = ~sh_dp[slot];
        end
      end
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".an_n"},       32'(bus.an_n),       32'(e_an));
    chk({where, ".code"},       32'(bus.code),       32'(e_code));
    chk({where, ".dp_n"},       32'(bus.dp_n),       32'(e_dp));
    chk({where, ".frame_done"}, 32'(bus.frame_done), 32'(e_fd));
  endtask

  task automatic step(input string where);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(where);
  endtask

  task automatic run(input string where, input int n);
    for (int i = 0; i < n; i++) step(where);
  endtask

  task automatic rand_inputs();
    if ($urandom_range(15) == 0) bus.digits     = 16'($urandom);
    if ($urandom_range(15) == 0) bus.dp_mask    = 4'($urandom);
    if ($urandom_range(15) == 0) bus.blink_mask = 4'($urandom);
    if ($urandom_range(63) == 0) bus.blink_en   = ~bus.blink_en;
    if (bus.scan_en) begin
      if ($urandom_range(199) == 0) bus.scan_en = 1'b0;
    end else if ($urandom_range(3) == 0) begin
      bus.scan_en = 1'b1;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.scan_en    = 1'b0;
    bus.digits     = 16'h0000;
    bus.dp_mask    = 4'b0000;
    bus.blink_mask = 4'b0000;
    bus.blink_en   = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic scan of 4321, then a mid-frame change that must wait for the next frame.
    bus.scan_en = 1'b1;
    bus.digits  = 16'h4321;
    run("scan", 12);
    bus.digits  = 16'h9999;
    run("coherent", 2 * FR);

    bus.digits  = 16'h4321;
    bus.dp_mask = 4'b0100;
    run("dp", 2 * FR);

    bus.dp_mask    = 4'b0000;
    bus.blink_en   = 1'b1;
    bus.blink_mask = 4'b0001;
    run("blink", 8 * FR);

    // Disable mid-DRIVE of slot 2, then re-enable with fresh digits.
    while (t % FR != 2 * SD + 4) step("align");
    bus.scan_en = 1'b0;
    run("disable", 3);
    bus.scan_en = 1'b1;
    bus.digits  = 16'hABCE;
    run("reenable", 2 * FR);

    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      step("rand");
    end

    // Async reset asserted between edges while a digit is lit.
    bus.scan_en  = 1'b1;
    bus.blink_en = 1'b0;
    for (int i = 0; i < 2 * FR && e_an == '1; i++) step("seek_drive");
    chk("pre_reset.drive", 32'(e_an != '1), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.digits = 16'h5678;
    run("post_reset", 2 * FR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
